// File: rtl/tanh_inverse_search_4bit.sv
// rtl/tanh_inverse_search_4bit.sv - 4-step binary-search inverse of the 4-bit tanh table
// Optional macro TANH_INV_EXACT_FLAG_EN adds the Out1_exact output.
module tanh_inverse_search_4bit #(
  parameter logic [3:0] CLAMP_MAX = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       In_valid,
  output logic       In_ready,
  input  logic [3:0] In,
  output logic       Out1_valid,
  input  logic       Out1_ready,
  output logic [3:0] Out1,
  output logic       Busy
`ifdef TANH_INV_EXACT_FLAG_EN
  ,
  output logic       Out1_exact
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t     state;
  logic [3:0] y;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [1:0] cnt;
  logic [4:0] sum;
  logic [3:0] mid;
  logic [3:0] lo_next;
  logic [3:0] hi_next;

  // Exact forward table: round(16*tanh(x/4)) clamped to 15.
  function automatic logic [3:0] fwd(input logic [3:0] x);
    case (x)
      4'd0:    fwd = 4'd0;
      4'd1:    fwd = 4'd4;
      4'd2:    fwd = 4'd7;
      4'd3:    fwd = 4'd10;
      4'd4:    fwd = 4'd12;
      4'd5:    fwd = 4'd14;
      4'd6:    fwd = 4'd14;
      default: fwd = 4'd15;
    endcase
  endfunction

  always_comb begin
    sum     = {1'b0, lo} + {1'b0, hi};
    mid     = sum[4:1];
    lo_next = lo;
    hi_next = hi;
    if (lo < hi) begin
      if (fwd(mid) >= y) hi_next = mid;
      else               lo_next = mid + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      y          <= 4'd0;
      lo         <= 4'd0;
      hi         <= 4'd0;
      cnt        <= 2'd0;
      In_ready   <= 1'b0;
      Out1_valid <= 1'b0;
      Out1       <= 4'd0;
      Busy       <= 1'b0;
`ifdef TANH_INV_EXACT_FLAG_EN
      Out1_exact <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (In_valid && In_ready) begin
            y        <= In;
            lo       <= 4'd0;
            hi       <= CLAMP_MAX;
            cnt      <= 2'd0;
            state    <= SEARCH;
            In_ready <= 1'b0;
            Busy     <= 1'b1;
          end else begin
            In_ready <= 1'b1;
          end
        end
        SEARCH: begin
          lo  <= lo_next;
          hi  <= hi_next;
          cnt <= cnt + 2'd1;
          // Result is taken from the post-step bound so it appears on the 4th edge.
          if (cnt == 2'd3) begin
            state      <= DONE;
            Out1_valid <= 1'b1;
            Out1       <= lo_next;
`ifdef TANH_INV_EXACT_FLAG_EN
            Out1_exact <= (fwd(lo_next) == y);
`endif
          end
        end
        DONE: begin
          if (Out1_ready) begin
            state      <= IDLE;
            Out1_valid <= 1'b0;
            Busy       <= 1'b0;
            In_ready   <= 1'b1;
`ifdef TANH_INV_EXACT_FLAG_EN
            Out1_exact <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tanh_inverse_search_4bit.sv
// tb/tb_tanh_inverse_search_4bit.sv - scoreboard bench for tanh_inverse_search_4bit (CLAMP_MAX 15 and 2)
module tb_tanh_inverse_search_4bit;

  typedef struct {
    logic [3:0] xa;
    logic [3:0] xb;
    logic       ea;
    logic       eb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       In_valid = 1'b0;
  logic [3:0] In = 4'd0;
  logic       Out1_ready = 1'b1;

  logic       in_ready_a, out_valid_a, busy_a, exact_a;
  logic       in_ready_b, out_valid_b, busy_b, exact_b;
  logic [3:0] out_a, out_b;

  int tests = 0;
  int fails = 0;
  exp_t q[$];

  logic [3:0] tt    [16] = '{0,4,7,10,12,14,14,15,15,15,15,15,15,15,15,15};
  logic [3:0] exp15 [16] = '{0,1,1,1,1,2,2,2,3,3,3,4,4,5,5,7};

  tanh_inverse_search_4bit #(.CLAMP_MAX(4'd15)) dut_a (
    .clk(clk), .rst_n(rst_n), .In_valid(In_valid), .In_ready(in_ready_a), .In(In),
    .Out1_valid(out_valid_a), .Out1_ready(Out1_ready), .Out1(out_a), .Busy(busy_a)
`ifdef TANH_INV_EXACT_FLAG_EN
    , .Out1_exact(exact_a)
`endif
  );

  tanh_inverse_search_4bit #(.CLAMP_MAX(4'd2)) dut_b (
    .clk(clk), .rst_n(rst_n), .In_valid(In_valid), .In_ready(in_ready_b), .In(In),
    .Out1_valid(out_valid_b), .Out1_ready(Out1_ready), .Out1(out_b), .Busy(busy_b)
`ifdef TANH_INV_EXACT_FLAG_EN
    , .Out1_exact(exact_b)
`endif
  );

`ifndef TANH_INV_EXACT_FLAG_EN
  assign exact_a = 1'b0;
  assign exact_b = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Smallest x in 0..clamp with T(x) >= y, else clamp (linear scan).
  function automatic logic [3:0] inv_model(input logic [3:0] yv, input int clamp);
    for (int x = 0; x <= clamp; x++)
      if (tt[x] >= yv) return 4'(x);
    return 4'(clamp);
  endfunction

  task automatic send(input logic [3:0] yv);
    int   n;
    exp_t e;
    n = 0;
    while (in_ready_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {7'd0, n < 20}, 8'd1);
    In       = yv;
    In_valid = 1'b1;
    e.xa = exp15[yv];
    e.xb = inv_model(yv, 2);
    e.ea = (tt[e.xa] == yv);
    e.eb = (tt[e.xb] == yv);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    In_valid = 1'b0;
    In       = 4'($urandom_range(0, 15));
  endtask

  task automatic collect();
    int   lat;
    int   low;
    exp_t e;
    lat = 0;
    low = (in_ready_a === 1'b1) ? 0 : 1;
    while (out_valid_a !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (in_ready_a !== 1'b1) low++;
    end
    check("latency", 8'(lat), 8'd4);
    check("valid_b", {7'd0, out_valid_b}, 8'd1);
    if (q.size() == 0) begin
      check("queue_nonempty", 8'd0, 8'd1);
    end else begin
      e = q.pop_front();
      check("out_clamp15", {4'd0, out_a}, {4'd0, e.xa});
      check("out_clamp2", {4'd0, out_b}, {4'd0, e.xb});
`ifdef TANH_INV_EXACT_FLAG_EN
      check("exact_clamp15", {7'd0, exact_a}, {7'd0, e.ea});
      check("exact_clamp2", {7'd0, exact_b}, {7'd0, e.eb});
`endif
    end
    if (Out1_ready === 1'b1) begin
      @(negedge clk);
      check("in_ready_low_cycles", 8'(low), 8'd5);
      check("in_ready_back", {7'd0, in_ready_a}, 8'd1);
      check("valid_drop", {7'd0, out_valid_a}, 8'd0);
    end
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {7'd0, in_ready_a}, 8'd0);
    check("rst_valid", {7'd0, out_valid_a}, 8'd0);
    check("rst_out", {4'd0, out_a}, 8'd0);
    check("rst_busy", {7'd0, busy_a}, 8'd0);
    check("rst_exact", {7'd0, exact_a}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {7'd0, in_ready_a}, 8'd1);

    // Directed single transactions.
    send(4'd0);  check("busy_search", {7'd0, busy_a}, 8'd1); collect();
    send(4'd9);  collect();
    send(4'd12); collect();
    send(4'd15); collect();

    // Back-to-back sweep.
    for (int yv = 0; yv < 16; yv++) begin
      send(4'(yv));
      collect();
    end

    // Output backpressure with a competing request.
    Out1_ready = 1'b0;
    send(4'd6);
    collect();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        In_valid = 1'b1;
        In       = 4'd1;
      end
      check("stall_out", {4'd0, out_a}, 8'd2);
      check("stall_valid", {7'd0, out_valid_a}, 8'd1);
      check("stall_in_ready", {7'd0, in_ready_a}, 8'd0);
    end
    In_valid   = 1'b0;
    Out1_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {7'd0, out_valid_a}, 8'd0);
    check("idle_exact", {7'd0, exact_a}, 8'd0);
    repeat (3) @(negedge clk);
    check("no_spurious_accept", {7'd0, busy_a}, 8'd0);

    // Reset during the second search step.
    send(4'd14);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", {7'd0, out_valid_a}, 8'd0);
    check("midrst_out", {4'd0, out_a}, 8'd0);
    check("midrst_busy", {7'd0, busy_a}, 8'd0);
    check("midrst_in_ready", {7'd0, in_ready_a}, 8'd0);
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_in_ready_after", {7'd0, in_ready_a}, 8'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_a === 1'b1 || out_valid_b === 1'b1) seen++;
    end
    check("midrst_no_result", 8'(seen), 8'd0);

    // Fresh transaction after the aborted one.
    send(4'd4);
    collect();
    check("queue_empty", 8'(q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
